rsa_session_ctrl: RTL and testbench

Host-facing sequencer for the 256-bit modular exponentiation datapath (`power`). It collects key and ciphertext material byte-serially from the host link and drives one exponentiation per ciphertext block. It then streams each result back to the host. It sits between the byte-wide RS-232/host FIFO interface and the `power` core; keys persist across blocks until reset.

---
 rtl/rsa_pkg.sv | 8 +
 rtl/rsa_session_ctrl_if.sv | 11 +
 rtl/rsa_byte_sipo.sv | 18 +
 rtl/rsa_session_ctrl.sv | 71 +++++++
 tb/tb_rsa_session_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: shared sizes and sequencer state encoding for the RSA session controller.
package rsa_pkg;
  localparam int NBITS = 256;
  localparam int IN_BYTES = NBITS / 8;
  localparam int OUT_BYTES = 31;
  localparam int GUARD = 2;
  typedef enum logic [2:0] {LOAD_N, LOAD_D, LOAD_C, START, FALL, WAIT, SEND} rsa_state_t;
endpackage

// File: rtl/rsa_session_ctrl_if.sv
// rsa_session_ctrl_if: byte-wide host link, rx toward the controller and tx back to the host.
interface rsa_session_ctrl_if;
  logic rx_valid;
  logic rx_ready;
  logic [7:0] rx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] tx_data;
  modport master (output rx_valid, rx_data, tx_ready, input rx_ready, tx_valid, tx_data);
  modport slave (input rx_valid, rx_data, tx_ready, output rx_ready, tx_valid, tx_data);
endinterface

// File: rtl/rsa_byte_sipo.sv
// rsa_byte_sipo: MSB-first byte shift-in register with load enable and synchronous clear.
module rsa_byte_sipo #(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       din,
  output logic [NBITS-1:0] q
);
  logic [NBITS-1:0] q_q, q_d;
  always_comb q_d = clr ? '0 : en ? {q_q[NBITS-9:0], din} : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/rsa_session_ctrl.sv
// rsa_session_ctrl: loads N, d and ciphertext blocks from the host, runs the power core, streams results back.
module rsa_session_ctrl
  import rsa_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  rsa_session_ctrl_if.slave   host,
  output logic                pw_start,
  output logic [NBITS-1:0]    pw_a1,
  output logic [NBITS-1:0]    pw_a2,
  output logic [NBITS-1:0]    pw_a3,
  input  logic                pw_done,
  input  logic [NBITS-1:0]    pw_a0,
  output logic                busy
);
  rsa_state_t state_q, state_d;
  logic [5:0] byte_cnt_q, byte_cnt_d;
  logic [8*OUT_BYTES-1:0] res_sr_q, res_sr_d;
  logic rx_fire, tx_fire, last_in, pw_a0_unused;
  assign host.rx_ready = state_q inside {LOAD_N, LOAD_D, LOAD_C};
  assign host.tx_valid = state_q == SEND;
  assign host.tx_data = host.tx_valid ? res_sr_q[8*OUT_BYTES-1 -: 8] : 8'h00;
  assign pw_start = state_q == START;
  assign busy = !(state_q == LOAD_C && byte_cnt_q == 6'd0);
  assign rx_fire = host.rx_valid && host.rx_ready;
  assign tx_fire = host.tx_valid && host.tx_ready;
  assign last_in = byte_cnt_q == 6'(IN_BYTES - 1);
  assign pw_a0_unused = ^pw_a0[NBITS-1:8*OUT_BYTES];
  // byte_cnt doubles as the guard timer while in FALL
  always_comb begin
    state_d = state_q;
    byte_cnt_d = byte_cnt_q + 6'(rx_fire || tx_fire || state_q == FALL);
    res_sr_d = tx_fire ? {res_sr_q[8*OUT_BYTES-9:0], 8'h00} : res_sr_q;
    case (state_q)
      LOAD_N: state_d = rx_fire && last_in ? LOAD_D : LOAD_N;
      LOAD_D: state_d = rx_fire && last_in ? LOAD_C : LOAD_D;
      LOAD_C: state_d = rx_fire && last_in ? START : LOAD_C;
      START:  state_d = FALL;
      FALL:   state_d = byte_cnt_q == 6'(GUARD - 1) ? WAIT : FALL;
      WAIT: begin
        state_d = pw_done ? SEND : WAIT;
        res_sr_d = pw_done ? pw_a0[8*OUT_BYTES-1:0] : res_sr_q;
      end
      SEND:   state_d = tx_fire && byte_cnt_q == 6'(OUT_BYTES - 1) ? LOAD_C : SEND;
      default: state_d = LOAD_N;
    endcase
    if (state_d != state_q) byte_cnt_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD_N;
      byte_cnt_q <= '0;
      res_sr_q <= '0;
    end else begin
      state_q <= state_d;
      byte_cnt_q <= byte_cnt_d;
      res_sr_q <= res_sr_d;
    end
  rsa_byte_sipo #(.NBITS(NBITS)) u_sipo_n (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(rx_fire && state_q == LOAD_N),
    .din(host.rx_data), .q(pw_a3)
  );
  rsa_byte_sipo #(.NBITS(NBITS)) u_sipo_d (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(rx_fire && state_q == LOAD_D),
    .din(host.rx_data), .q(pw_a2)
  );
  rsa_byte_sipo #(.NBITS(NBITS)) u_sipo_c (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(rx_fire && state_q == LOAD_C),
    .din(host.rx_data), .q(pw_a1)
  );
endmodule

// File: tb/tb_rsa_session_ctrl.sv
// tb_rsa_session_ctrl: randomized host/core stimulus against a byte-level reference of the session protocol.
module tb_rsa_session_ctrl;
  import rsa_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pw_start, busy;
  logic pw_done = 1'b0;
  logic [NBITS-1:0] pw_a1, pw_a2, pw_a3;
  logic [NBITS-1:0] pw_a0 = '0;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  rsa_session_ctrl_if h();
  rsa_session_ctrl dut (
    .clk(clk), .rst_n(rst_n), .host(h), .pw_start(pw_start), .pw_a1(pw_a1),
    .pw_a2(pw_a2), .pw_a3(pw_a3), .pw_done(pw_done), .pw_a0(pw_a0), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [NBITS-1:0] got, input logic [NBITS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [NBITS-1:0] rand256();
    logic [NBITS-1:0] v;
    for (int i = 0; i < NBITS / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction
  task automatic check_reset(input string tag);
    check({tag, "_a1"}, pw_a1, '0);
    check({tag, "_a2"}, pw_a2, '0);
    check({tag, "_a3"}, pw_a3, '0);
    check({tag, "_start"}, pw_start, 0);
    check({tag, "_txv"}, h.tx_valid, 0);
    check({tag, "_txd"}, h.tx_data, 0);
    check({tag, "_rxr"}, h.rx_ready, 1);
    check({tag, "_busy"}, busy, 1);
  endtask
  // Entered at a falling edge; sends the nb most significant bytes of v, returns the last accept cycle.
  task automatic load_op(input logic [NBITS-1:0] v, input int nb, input bit gaps, input bit is_c,
                         output int t_last);
    t_last = cyc;
    for (int i = 0; i < nb; i++) begin
      while (gaps && $urandom_range(3) == 0) begin
        h.rx_valid = 1'b0;
        @(negedge clk);
      end
      h.rx_valid = 1'b1;
      h.rx_data = v[NBITS-1-8*i -: 8];
      #1;
      check("load_rx_ready", h.rx_ready, 1);
      check("load_busy", busy, !(is_c && i == 0));
      check("load_no_start", pw_start, 0);
      t_last = cyc;
      @(negedge clk);
    end
    h.rx_valid = 1'b0;
  endtask
  // One ciphertext block: load c, core answers r after lat cycles (or stale done held), drain result.
  task automatic run_block(input logic [NBITS-1:0] c, input logic [NBITS-1:0] r, input bit stale,
                           input int lat, input int mode, input bit gaps,
                           input logic [NBITS-1:0] n, input logic [NBITS-1:0] d);
    int t, w, got;
    load_op(c, IN_BYTES, gaps, 1'b1, t);
    w = stale ? t + 2 + GUARD : (lat > GUARD + 1 ? t + 1 + lat : t + 2 + GUARD);
    for (int x = t + 1; x <= w; x++) begin
      if (x == t + 1) begin
        pw_done = stale;
        if (stale) pw_a0 = r;
      end
      if (!stale && x == t + 1 + lat) begin
        pw_a0 = r;
        pw_done = 1'b1;
      end
      h.rx_valid = 1'($urandom_range(1));
      h.rx_data = 8'($urandom);
      #1;
      check("start_pulse", pw_start, x == t + 1);
      check("tx_early", h.tx_valid, 0);
      check("rx_ready_busy", h.rx_ready, 0);
      if (x == t + 1) begin
        check("a1_loaded", pw_a1, c);
        check("a2_kept", pw_a2, d);
        check("a3_kept", pw_a3, n);
      end
      @(negedge clk);
    end
    h.rx_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 400 && got < OUT_BYTES; k++) begin
      h.tx_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(k % 2) : 1'($urandom_range(1));
      #1;
      check("tx_valid", h.tx_valid, 1);
      check("tx_byte", h.tx_data, r[8*(OUT_BYTES-1-got) +: 8]);
      if (h.tx_ready) got++;
      @(negedge clk);
    end
    check("tx_count", got, OUT_BYTES);
    h.tx_ready = 1'b0;
    #1;
    check("tx_done_valid", h.tx_valid, 0);
    check("post_rx_ready", h.rx_ready, 1);
    check("post_busy", busy, 0);
    check("a1_unchanged", pw_a1, c);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    int t;
    logic [NBITS-1:0] n, d;
    h.rx_valid = 1'b0;
    h.rx_data = 8'h00;
    h.tx_ready = 1'b0;
    #2;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    n = 256'hD;
    d = 256'h5;
    load_op(n, IN_BYTES, 1'b0, 1'b0, t);
    load_op(d, IN_BYTES, 1'b0, 1'b0, t);
    #1;
    check("n_loaded", pw_a3, n);
    check("d_loaded", pw_a2, d);
    run_block(256'h7, 256'h0A0B, 1'b0, 100, 0, 1'b0, n, d);
    run_block(rand256(), rand256(), 1'b1, 0, 1, 1'b0, n, d);
    run_block(rand256(), rand256(), 1'b0, int'($urandom_range(1, 20)), 2, 1'b1, n, d);
    load_op(rand256(), IN_BYTES, 1'b0, 1'b1, t);
    pw_done = 1'b0;
    repeat (GUARD + 3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("rst_wait");
    @(negedge clk);
    #1;
    check_reset("rst_wait_hold");
    rst_n = 1'b1;
    @(negedge clk);
    load_op(rand256(), IN_BYTES, 1'b1, 1'b0, t);
    load_op(rand256(), 17, 1'b0, 1'b0, t);
    rst_n = 1'b0;
    #1;
    check_reset("rst_load_d");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n = rand256();
    d = rand256();
    load_op(n, IN_BYTES, 1'b1, 1'b0, t);
    load_op(d, IN_BYTES, 1'b1, 1'b0, t);
    run_block(rand256(), rand256(), 1'b0, int'($urandom_range(1, 40)), 2, 1'b1, n, d);
    run_block(rand256(), rand256(), 1'b1, 0, 2, 1'b1, n, d);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
